// File: rtl/corelet_pkg.sv
// Shared corelet definitions: instruction word layout, idle word and sequencer phases.
// Both the instruction sequencer and the corelet decoder import this package.
package corelet_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 34;

  localparam int ACC_B      = 33;
  localparam int CENP_B     = 32;
  localparam int WENP_B     = 31;
  localparam int AP_LSB     = 20;
  localparam int CENX_B     = 19;
  localparam int WENX_B     = 18;
  localparam int AX_LSB     = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  // Both SRAMs deselected and write-disabled, everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    PH_IDLE,
    PH_W_LD,
    PH_W_KL,
    PH_W_FLUSH,
    PH_A_LD,
    PH_EXE,
    PH_DRAIN,
    PH_P_WR,
    PH_ACC,
    PH_DONE
  } phase_e;

endpackage

// File: rtl/corelet_inst_seq_cnt.sv
// Up-counter with synchronous clear, hold when inc_i is low, and a terminal flag at lim_i.
module seq_cnt #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == lim_i);

endmodule

// File: rtl/corelet_inst_seq.sv
// Weight-stationary conv layer instruction sequencer: per kernel index load weights,
// load activations, execute, drain psums to pmem, then run the accumulate pass.
import corelet_pkg::*;

module corelet_inst_seq #(
  parameter int ROW   = 8,
  parameter int COL   = 8,
  parameter int LEN_W = 11,
  parameter int NK_W  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [NK_W-1:0]   num_k_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] p_base_i,
  input  logic              ofifo_valid_i,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o,
  output logic              done_o
);

  phase_e             state_q;
  logic [INST_W-1:0]  inst_q, word_d;
  logic               busy_q, done_q;
  logic [NK_W-1:0]    nk_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  w_base_q, x_base_q, p_base_q;

  logic [LEN_W-1:0]   i_cnt, i_lim;
  logic [NK_W-1:0]    k_cnt, kk_cnt;
  logic               i_last, k_last, kk_last, i_run;
  logic [ADDR_W-1:0]  xa_w, pa_wr, pa_acc;

  // i runs only while its phase advances; in ACC it is the outer index o and steps on kk wrap.
  always_comb begin
    i_lim = '0;
    i_run = 1'b0;
    unique case (state_q)
      PH_W_LD:    begin i_lim = LEN_W'(ROW);     i_run = 1'b1;          end
      PH_W_KL:    begin i_lim = LEN_W'(ROW - 1); i_run = 1'b1;          end
      PH_W_FLUSH: begin i_lim = LEN_W'(COL - 1); i_run = 1'b1;          end
      PH_A_LD:    begin i_lim = len_q;           i_run = 1'b1;          end
      PH_EXE:     begin i_lim = len_q - LEN_W'(1); i_run = 1'b1;        end
      PH_P_WR:    begin i_lim = len_q - LEN_W'(1); i_run = ofifo_valid_i; end
      PH_ACC:     begin i_lim = len_q - LEN_W'(1); i_run = kk_last;     end
      default: ;
    endcase
  end

  seq_cnt #(.W(LEN_W)) u_cnt_i (
    .clk_i, .reset_i,
    .clr_i  ((state_q == PH_IDLE) || (i_run && i_last)),
    .inc_i  (i_run),
    .lim_i  (i_lim),
    .cnt_o  (i_cnt),
    .last_o (i_last)
  );

  seq_cnt #(.W(NK_W)) u_cnt_k (
    .clk_i, .reset_i,
    .clr_i  (state_q == PH_IDLE),
    .inc_i  ((state_q == PH_P_WR) && ofifo_valid_i && i_last && !k_last),
    .lim_i  (nk_q - NK_W'(1)),
    .cnt_o  (k_cnt),
    .last_o (k_last)
  );

  seq_cnt #(.W(NK_W)) u_cnt_kk (
    .clk_i, .reset_i,
    .clr_i  ((state_q != PH_ACC) || kk_last),
    .inc_i  (state_q == PH_ACC),
    .lim_i  (nk_q - NK_W'(1)),
    .cnt_o  (kk_cnt),
    .last_o (kk_last)
  );

  assign xa_w   = w_base_q + ADDR_W'(k_cnt) * ADDR_W'(ROW) + ADDR_W'(i_cnt);
  assign pa_wr  = p_base_q + ADDR_W'(k_cnt) * ADDR_W'(len_q) + ADDR_W'(i_cnt);
  assign pa_acc = p_base_q + ADDR_W'(kk_cnt) * ADDR_W'(len_q) + ADDR_W'(i_cnt);

  // The load phases run one extra cycle: xmem read data lands in L0 a cycle after its address.
  always_comb begin
    word_d = INST_IDLE;
    unique case (state_q)
      PH_W_LD: begin
        if (i_cnt < LEN_W'(ROW)) begin
          word_d[CENX_B]             = 1'b0;
          word_d[AX_LSB +: ADDR_W]   = xa_w;
        end
        word_d[L0_WR_B] = (i_cnt != '0);
      end
      PH_W_KL: begin
        word_d[L0_RD_B] = 1'b1;
        word_d[LOAD_B]  = 1'b1;
      end
      PH_A_LD: begin
        if (i_cnt < len_q) begin
          word_d[CENX_B]             = 1'b0;
          word_d[AX_LSB +: ADDR_W]   = x_base_q + ADDR_W'(i_cnt);
        end
        word_d[L0_WR_B] = (i_cnt != '0);
      end
      PH_EXE: begin
        word_d[L0_RD_B] = 1'b1;
        word_d[EXEC_B]  = 1'b1;
      end
      PH_P_WR: begin
        if (ofifo_valid_i) begin
          word_d[OFIFO_RD_B]       = 1'b1;
          word_d[CENP_B]           = 1'b0;
          word_d[WENP_B]           = 1'b0;
          word_d[AP_LSB +: ADDR_W] = pa_wr;
        end
      end
      PH_ACC: begin
        word_d[ACC_B]            = 1'b1;
        word_d[CENP_B]           = 1'b0;
        word_d[AP_LSB +: ADDR_W] = pa_acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= PH_IDLE;
      inst_q   <= INST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nk_q     <= '0;
      len_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
    end else begin
      inst_q <= word_d;
      done_q <= (state_q == PH_DONE);
      if (done_q) busy_q <= 1'b0;
      unique case (state_q)
        PH_IDLE: if (start_i) begin
          nk_q     <= num_k_i;
          len_q    <= len_i;
          w_base_q <= w_base_i;
          x_base_q <= x_base_i;
          p_base_q <= p_base_i;
          // An empty layer skips every phase and reports completion straight away.
          if (num_k_i == '0 || len_i == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= PH_W_LD;
            busy_q  <= 1'b1;
          end
        end
        PH_W_LD:    if (i_last) state_q <= PH_W_KL;
        PH_W_KL:    if (i_last) state_q <= PH_W_FLUSH;
        PH_W_FLUSH: if (i_last) state_q <= PH_A_LD;
        PH_A_LD:    if (i_last) state_q <= PH_EXE;
        PH_EXE:     if (i_last) state_q <= PH_DRAIN;
        PH_DRAIN:   if (ofifo_valid_i) state_q <= PH_P_WR;
        PH_P_WR:    if (ofifo_valid_i && i_last) state_q <= k_last ? PH_ACC : PH_W_LD;
        PH_ACC:     if (i_last && kk_last) state_q <= PH_DONE;
        PH_DONE:    state_q <= PH_IDLE;
        default:    state_q <= PH_IDLE;
      endcase
    end
  end

  assign inst_o = inst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_corelet_inst_seq.sv
// Directed bench for corelet_inst_seq: a loop-level model lists every non-idle instruction
// of a layer in order; a per-cycle monitor pops and compares, literal checks pin the model.
module tb_corelet_inst_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, ofv = 1'b1;
  logic [3:0]  nk = '0;
  logic [10:0] ln = '0, wb = '0, xb = '0, pb = '0;
  logic [33:0] inst;
  logic        busy, done;

  corelet_inst_seq dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .num_k_i(nk), .len_i(ln),
    .w_base_i(wb), .x_base_i(xb), .p_base_i(pb), .ofifo_valid_i(ofv),
    .inst_o(inst), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [33:0] exp_q[$];
  int xaddr_q[$], xgap_q[$], paddr_q[$], pgap_q[$], acc_q[$];
  int n_l0wr = 0, n_exe = 0, done_cnt = 0, idle_run = 0;
  bit chk_en = 1'b0, active = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Field order: acc,CEN_p,WEN_p,A_p,CEN_x,WEN_x,A_x,ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load
  function automatic logic [33:0] mk(input bit acc, input bit cenp, input bit wenp,
                                     input logic [10:0] ap, input bit cenx, input bit wenx,
                                     input logic [10:0] ax, input bit ofrd, input bit l0rd,
                                     input bit l0wr, input bit exe, input bit ld);
    return {acc, cenp, wenp, ap, cenx, wenx, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
  endfunction

  task automatic build_exp(input int k_n, input int l_n, input int w_b, input int x_b, input int p_b);
    exp_q.delete();
    for (int k = 0; k < k_n; k++) begin
      for (int i = 0; i <= ROW; i++)
        exp_q.push_back(i < ROW ? mk(0,1,1,0,0,1,11'(w_b + k*ROW + i),0,0,(i >= 1),0,0)
                                : mk(0,1,1,0,1,1,0,0,0,1,0,0));
      for (int i = 0; i < ROW; i++) exp_q.push_back(mk(0,1,1,0,1,1,0,0,1,0,0,1));
      for (int i = 0; i <= l_n; i++)
        exp_q.push_back(i < l_n ? mk(0,1,1,0,0,1,11'(x_b + i),0,0,(i >= 1),0,0)
                                : mk(0,1,1,0,1,1,0,0,0,1,0,0));
      for (int i = 0; i < l_n; i++) exp_q.push_back(mk(0,1,1,0,1,1,0,0,1,0,1,0));
      for (int i = 0; i < l_n; i++) exp_q.push_back(mk(0,0,0,11'(p_b + k*l_n + i),1,1,0,1,0,0,0,0));
    end
    for (int o = 0; o < l_n; o++)
      for (int kk = 0; kk < k_n; kk++)
        exp_q.push_back(mk(1,0,1,11'(p_b + kk*l_n + o),1,1,0,0,0,0,0,0));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (inst !== IDLE_W) begin
        if (exp_q.size() == 0) chk("extra_word", inst, IDLE_W);
        else chk("inst", inst, exp_q.pop_front());
        if (!inst[19]) begin xaddr_q.push_back(int'(inst[17:7])); xgap_q.push_back(idle_run); end
        if (!inst[32] && !inst[31]) begin paddr_q.push_back(int'(inst[30:20])); pgap_q.push_back(idle_run); end
        if (inst[33]) acc_q.push_back(int'(inst[30:20]));
        if (inst[2]) n_l0wr++;
        if (inst[1]) n_exe++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (active) chk("busy_active", busy, 1);
      if (done) begin
        done_cnt++;
        chk("done_after_last_word", exp_q.size(), 0);
        active = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    xaddr_q.delete(); xgap_q.delete(); paddr_q.delete(); pgap_q.delete(); acc_q.delete();
    n_l0wr = 0; n_exe = 0; done_cnt = 0; idle_run = 0;
  endtask

  task automatic run_layer(input int k_n, input int l_n, input int w_b, input int x_b,
                           input int p_b, input bit stall, input bit poke);
    int stall_n = 0;
    bit fin = 1'b0;
    build_exp(k_n, l_n, w_b, x_b, p_b);
    clear_logs();
    @(negedge clk);
    nk = 4'(k_n); ln = 11'(l_n); wb = 11'(w_b); xb = 11'(x_b); pb = 11'(p_b);
    start = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    start = 1'b0; active = 1'b1;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) fin = 1'b1;
      if (poke) begin
        start = (c == 30);
        if (c == 30) ln = '0;
      end
      if (stall && paddr_q.size() == 2 && stall_n < 3) begin ofv = 1'b0; stall_n++; end
      else ofv = 1'b1;
    end
    start = 1'b0; ofv = 1'b1;
    if (!fin) chk("layer_timeout", 0, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("done_once", done_cnt, 1);
    @(negedge clk);
    chk("done_low_after", done, 0);
    chk("busy_low_after", busy, 0);
    chk_en = 1'b0; active = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_inst", inst, IDLE_W);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Single kernel index, len 4.
    run_layer(1, 4, 0, 16, 0, 1'b0, 1'b0);
    chk("l1_xreads", xaddr_q.size(), 12);
    if (xaddr_q.size() == 12) begin
      chk("l1_x0", xaddr_q[0], 0);
      chk("l1_x7", xaddr_q[7], 7);
      chk("l1_x8", xaddr_q[8], 16);
      chk("l1_x11", xaddr_q[11], 19);
      chk("l1_flush_gap", xgap_q[8], COL);
    end
    chk("l1_l0wr", n_l0wr, 12);
    chk("l1_exe", n_exe, 4);
    chk("l1_pwr", paddr_q.size(), 4);
    if (paddr_q.size() == 4) chk("l1_p3", paddr_q[3], 3);
    chk("l1_acc", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      chk("l1_acc0", acc_q[0], 0);
      chk("l1_acc3", acc_q[3], 3);
    end

    // 3x3 kernel, len 16, weight addresses wrap, start (len=0) poked while busy.
    run_layer(9, 16, 2040, 200, 0, 1'b0, 1'b1);
    chk("l9_pwr", paddr_q.size(), 144);
    if (paddr_q.size() == 144) chk("l9_p_last", paddr_q[143], 143);
    if (xaddr_q.size() > 24) chk("l9_wrap", xaddr_q[24], 0);
    chk("l9_acc", acc_q.size(), 144);
    if (acc_q.size() == 144) begin
      chk("l9_acc1", acc_q[1], 16);
      chk("l9_acc8", acc_q[8], 128);
      chk("l9_acc9", acc_q[9], 1);
      chk("l9_acc_last", acc_q[143], 143);
    end

    // OFIFO runs dry for three cycles in the middle of the first psum write-out.
    run_layer(2, 4, 0, 16, 0, 1'b1, 1'b0);
    chk("st_pwr", paddr_q.size(), 8);
    if (paddr_q.size() == 8) begin
      chk("st_gap2", pgap_q[2], 3);
      chk("st_gap3", pgap_q[3], 0);
      chk("st_p2", paddr_q[2], 2);
      chk("st_p3", paddr_q[3], 3);
    end

    // Reset in the middle of EXE, then a clean layer.
    begin
      bit hit = 1'b0;
      build_exp(1, 8, 0, 32, 0);
      clear_logs();
      @(negedge clk);
      nk = 4'd1; ln = 11'd8; wb = '0; xb = 11'd32; pb = '0; start = 1'b1; chk_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(negedge clk); #1;
        if (n_exe > 1) hit = 1'b1;
      end
      if (!hit) chk("exe_timeout", 0, 1);
      chk_en = 1'b0; active = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("abort_inst", inst, IDLE_W);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      reset = 1'b0;
    end
    run_layer(1, 4, 8, 40, 100, 1'b0, 1'b0);
    if (paddr_q.size() == 4) chk("post_abort_p0", paddr_q[0], 100);

    // Empty layers: done next cycle, no non-idle word.
    for (int z = 0; z < 2; z++) begin
      exp_q.delete(); clear_logs(); chk_en = 1'b1;
      @(negedge clk);
      nk = (z == 0) ? 4'd3 : 4'd0; ln = (z == 0) ? 11'd0 : 11'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      repeat (4) @(negedge clk);
      chk("zero_done_cnt", done_cnt, 1);
      chk_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
